// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: ALUControl encodings and FSM states.
// The ALU decoder bench imports the same constants so both sides agree on the encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic alu_op_supported(input logic [2:0] op);
        return (op != 3'b101) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done_o and product_o are combinational during the final step so the caller can latch the
// finished product on the same edge that retires the last step.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign product_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            acc_q    <= '0;
            mplier_q <= b_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshakes: single-cycle logic/arith ops and an
// iterative MUL, results held in DONE until the consumer takes them.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             err
);

    alu_state_e         state_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               zero_q;
    logic               err_q;

    logic               transfer;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   alu_res_d;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign transfer  = in_valid && in_ready;
    assign mul_start = transfer && (ALUControl == ALU_MUL);

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign err       = err_q;

    always_comb begin
        alu_res_d = '0;
        case (ALUControl)
            ALU_AND: alu_res_d = src_a & src_b;
            ALU_OR:  alu_res_d = src_a | src_b;
            ALU_ADD: alu_res_d = src_a + src_b;
            ALU_SUB: alu_res_d = src_a - src_b;
            ALU_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_res_d = '0;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (src_a),
        .b_i       (src_b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Outputs are only rewritten on entry to DONE, so they hold through backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (transfer) begin
                        if (ALUControl == ALU_MUL) begin
                            state_q <= ST_MUL;
                        end else if (alu_op_supported(ALUControl)) begin
                            result_q    <= alu_res_d;
                            result_hi_q <= '0;
                            zero_q      <= (alu_res_d == '0);
                            err_q       <= 1'b0;
                            state_q     <= ST_DONE;
                        end else begin
                            result_q    <= '0;
                            result_hi_q <= '0;
                            zero_q      <= 1'b1;
                            err_q       <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result_q    <= mul_product[WIDTH-1:0];
                        result_hi_q <= mul_product[2*WIDTH-1:WIDTH];
                        zero_q      <= (mul_product[WIDTH-1:0] == '0);
                        err_q       <= 1'b0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
